// File: rtl/arm_memory_mp.sv
`default_nettype none
// ============================================================================
// Module      : arm_memory_mp
// Description : Parametrised N-port word memory with byte-lane writes,
//               registered reads, per-port access exceptions and a post-reset
//               clear sweep. Optional macro MEM_FWD_EN forwards same-edge
//               writes to reads of the same word.
// Revision    : 1.0 - initial release
// ============================================================================
module arm_memory_mp #(
    parameter int          NPORTS    = 2,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NPORTS*32-1:0]   addr,
    input  logic [NPORTS*32-1:0]   data_in,
    input  logic [NPORTS-1:0]      we,
    input  logic [NPORTS*4-1:0]    be,
    output logic [NPORTS-1:0]      excpt,
    output logic [NPORTS*32-1:0]   data_out,
    output logic                   ready
);

    localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_idx_w-1:0]    r_ptr;
    logic                  r_ready;
    logic [NPORTS-1:0]     r_excpt;
    logic [NPORTS*32-1:0]  r_data_out;
    logic [31:0]           r_mem [DEPTH];

    logic [c_idx_w-1:0]    w_idx [NPORTS];
    logic                  w_exc [NPORTS];
    logic                  w_wr  [NPORTS];
    logic [31:0]           w_rd  [NPORTS];

    // Range check is done on the offset from BASE_ADDR: any set bit above the
    // index field means the access lies past the end of the array.
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [31:0] w_addr;
        logic [31:0] w_off;
        assign w_addr   = addr[p*32 +: 32];
        assign w_off    = w_addr - BASE_ADDR;
        assign w_exc[p] = (w_addr < BASE_ADDR) || (w_off[1:0] != 2'b00) ||
                          (w_off[31:c_idx_w+2] != '0);
        assign w_idx[p] = w_off[c_idx_w+1:2];
        assign w_wr[p]  = we[p] && !w_exc[p] && (r_state == S_READY);
    end

`ifdef MEM_FWD_EN
    // Ascending port order lets the highest-indexed writer win each lane.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            w_rd[p] = r_mem[w_idx[p]];
            for (int q = 0; q < NPORTS; q++) begin
                if (w_wr[q] && (w_idx[q] == w_idx[p])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[q*4+b]) begin
                            w_rd[p][8*b +: 8] = data_in[q*32+8*b +: 8];
                        end
                    end
                end
            end
        end
    end
`else
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            w_rd[p] = r_mem[w_idx[p]];
        end
    end
`endif

    // Later non-blocking assignments override earlier ones, so the loop order
    // resolves same-lane collisions in favour of the highest port.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (w_wr[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[p*4+b]) begin
                            r_mem[w_idx[p]][8*b +: 8] <= data_in[p*32+8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_ptr      <= '0;
            r_ready    <= 1'b0;
            r_excpt    <= '0;
            r_data_out <= '0;
        end else if (r_state == S_CLEAR) begin
            r_ptr      <= r_ptr + 1'b1;
            r_excpt    <= '0;
            r_data_out <= '0;
            if (r_ptr == c_last) begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end else begin
            r_ready <= 1'b1;
            for (int p = 0; p < NPORTS; p++) begin
                r_excpt[p]            <= w_exc[p];
                r_data_out[p*32 +: 32] <= w_exc[p] ? 32'h0 : w_rd[p];
            end
        end
    end

    assign ready    = r_ready;
    assign excpt    = r_excpt;
    assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_arm_memory_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_memory_mp
// Description : Self-checking bench for arm_memory_mp against a word-array
//               reference model (directed cases plus random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_memory_mp;

    localparam int          NP    = 2;
    localparam int          DEPTH = 128;
    localparam logic [31:0] BASE  = 32'h0000_0400;
`ifdef MEM_FWD_EN
    localparam bit          FWD   = 1'b1;
`else
    localparam bit          FWD   = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*32-1:0]  addr;
    logic [NP*32-1:0]  data_in;
    logic [NP-1:0]     we;
    logic [NP*4-1:0]   be;
    logic [NP-1:0]     excpt;
    logic [NP*32-1:0]  data_out;
    logic              ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];

    arm_memory_mp #(.NPORTS(NP), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .we       (we),
        .be       (be),
        .excpt    (excpt),
        .data_out (data_out),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_exc(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (a[1:0] != 2'b00) || (la < longint'(BASE)) ||
               (la >= longint'(BASE) + 4 * DEPTH);
    endfunction

    task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [3:0] b);
        addr[p*32 +: 32]   = a;
        data_in[p*32 +: 32] = d;
        we[p]              = w;
        be[p*4 +: 4]       = b;
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) set_port(p, BASE, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // One READY-state access cycle: predict, clock, compare.
    task automatic cycle(input string tag);
        logic [31:0] rd_old [NP];
        logic [31:0] rd_new [NP];
        bit          ex     [NP];
        int          ix     [NP];
        for (int p = 0; p < NP; p++) begin
            ex[p]     = is_exc(addr[p*32 +: 32]);
            ix[p]     = ex[p] ? 0 : int'((addr[p*32 +: 32] - BASE) >> 2);
            rd_old[p] = ex[p] ? 32'h0 : model[ix[p]];
        end
        for (int p = 0; p < NP; p++) begin
            if (we[p] && !ex[p]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[p*4+b]) model[ix[p]][8*b +: 8] = data_in[p*32+8*b +: 8];
                end
            end
        end
        for (int p = 0; p < NP; p++) rd_new[p] = ex[p] ? 32'h0 : model[ix[p]];
        @(posedge clk);
        #1;
        chk($sformatf("%s.ready", tag), {31'h0, ready}, 32'h1);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("%s.excpt%0d", tag, p), {31'h0, excpt[p]}, {31'h0, ex[p]});
            chk($sformatf("%s.dout%0d", tag, p), data_out[p*32 +: 32],
                FWD ? rd_new[p] : rd_old[p]);
        end
    endtask

    // Observe n edges of the clear sweep while hammering the ports with writes.
    task automatic sweep(input int n);
        for (int k = 1; k <= n; k++) begin
            for (int p = 0; p < NP; p++)
                set_port(p, BASE + 4 * $urandom_range(0, DEPTH - 1), $urandom, 1'b1, 4'hF);
            @(posedge clk);
            #1;
            chk($sformatf("sweep%0d.ready", k), {31'h0, ready}, (k == DEPTH) ? 32'h1 : 32'h0);
            chk($sformatf("sweep%0d.dout", k), data_out[31:0] | data_out[63:32], 32'h0);
            chk($sformatf("sweep%0d.excpt", k), {30'h0, excpt}, 32'h0);
        end
        idle();
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            set_port(0, BASE + 4 * i, 32'h0, 1'b0, 4'h0);
            set_port(1, BASE + 4 * (DEPTH - 1 - i), 32'h0, 1'b0, 4'h0);
            cycle(tag);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r < 13)       return BASE + 4 * $urandom_range(0, 7);
        else if (r == 13) return BASE + 4 * (DEPTH - 1);
        else if (r == 14) return BASE + 4 * DEPTH;
        else if (r == 15) return BASE - 4;
        else if (r == 16) return BASE + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
        else if (r == 17) return $urandom;
        else              return BASE + 4 * $urandom_range(0, DEPTH - 1);
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", {31'h0, ready}, 32'h0);
        chk("rst.dout", data_out[31:0] | data_out[63:32], 32'h0);
        chk("rst.excpt", {30'h0, excpt}, 32'h0);

        // Clear sweep and all-zero contents
        rst_n = 1'b1;
        sweep(DEPTH);
        clear_model();
        read_all("init_rd");

        // Write then read on the other port
        set_port(0, BASE + 32'h10, 32'hDEADBEEF, 1'b1, 4'hF);
        cycle("t2w");
        idle();
        set_port(1, BASE + 32'h10, 32'h0, 1'b0, 4'h0);
        cycle("t2r");
        chk("t2.value", data_out[63:32], 32'hDEADBEEF);

        // Byte-lane merge
        idle();
        set_port(0, BASE + 32'h14, 32'h11223344, 1'b1, 4'hF);
        cycle("t3a");
        set_port(0, BASE + 32'h14, 32'hAABBCCDD, 1'b1, 4'b0101);
        cycle("t3b");
        set_port(0, BASE + 32'h14, 32'h0, 1'b0, 4'h0);
        cycle("t3r");
        chk("t3.value", data_out[31:0], 32'h11BB33DD);

        // Same-word collision, highest port wins, read-during-write
        set_port(0, BASE + 32'h20, 32'h00000055, 1'b1, 4'hF);
        cycle("t4a");
        set_port(0, BASE + 32'h20, 32'h00000001, 1'b1, 4'hF);
        set_port(1, BASE + 32'h20, 32'h00000002, 1'b1, 4'hF);
        cycle("t4b");
        chk("t4.rdw", data_out[31:0], FWD ? 32'h00000002 : 32'h00000055);
        idle();
        set_port(0, BASE + 32'h20, 32'h0, 1'b0, 4'h0);
        cycle("t4r");
        chk("t4.value", data_out[31:0], 32'h00000002);
        set_port(0, BASE + 32'h24, 32'hAAAAAAAA, 1'b1, 4'hF);
        set_port(1, BASE + 32'h24, 32'hBBBBBBBB, 1'b1, 4'h3);
        cycle("t4c");
        idle();
        set_port(1, BASE + 32'h24, 32'h0, 1'b0, 4'h0);
        cycle("t4cr");
        chk("t4.lanes", data_out[63:32], 32'hAAAABBBB);

        // Exceptions
        idle();
        set_port(0, 32'h00000003, 32'h0, 1'b0, 4'h0);
        cycle("t5a");
        chk("t5.excpt_mis", {31'h0, excpt[0]}, 32'h1);
        chk("t5.dout_mis", data_out[31:0], 32'h0);
        set_port(0, BASE + 4 * DEPTH, 32'hFFFFFFFF, 1'b1, 4'hF);
        set_port(1, BASE + 32'h30, 32'h12345678, 1'b1, 4'hF);
        cycle("t5b");
        chk("t5.excpt_oor", {30'h0, excpt}, 32'h1);
        set_port(0, BASE, 32'h0, 1'b0, 4'h0);
        set_port(1, BASE + 32'h30, 32'h0, 1'b0, 4'h0);
        cycle("t5c");
        chk("t5.p1_value", data_out[63:32], 32'h12345678);
        chk("t5.not_sticky", {31'h0, excpt[0]}, 32'h0);
        read_all("t5_rd");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++)
                set_port(p, rand_addr(), $urandom, 1'($urandom_range(0, 1)), 4'($urandom));
            cycle("rand");
        end
        idle();

        // Reset in READY, then mid-sweep at ptr=100
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.ready_async", {31'h0, ready}, 32'h0);
        chk("t6.dout_async", data_out[31:0] | data_out[63:32], 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep(100);
        rst_n = 1'b0;
        #1;
        chk("t6.ready_mid", {31'h0, ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep(DEPTH);
        clear_model();
        read_all("t6_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
